// File: rtl/shift_add_mult_n.sv
// Purpose : sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or two's-complement per operation.
// Latency : Done pulses WIDTH edges after the accepting edge; minimum initiation interval is WIDTH+2 edges.
// Backpressure: a start is taken only while Idle=1; St in CALC/DONE is dropped, never queued.
//
// Ports:
//   Clk                    sole clock, rising edge
//   Rst_n                  synchronous active-low reset
//   St                     start request (accepted only while Idle=1)
//   Sgn                    0 = unsigned, 1 = signed; sampled with St
//   Multiplicando          multiplicand M, sampled with St
//   OperandoMultiplicador  multiplier Q, sampled with St
//   Idle                   high in IDLE
//   Done                   one-cycle pulse after Produto is updated
//   Produto                result register, changes only at completion or reset
module shift_add_mult_n #(
    parameter int WIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 St,
    input  logic                 Sgn,
    input  logic [WIDTH-1:0]     Multiplicando,
    input  logic [WIDTH-1:0]     OperandoMultiplicador,
    output logic                 Idle,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Produto
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW    = 2*WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [WIDTH-1:0]       r_m;
    logic                   r_sgn;
    logic [AW-1:0]          r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_produto;

    logic                   w_accept;
    logic                   w_last;
    logic [WIDTH:0]         w_u;
    logic [WIDTH:0]         w_mext;
    logic [WIDTH:0]         w_u_new;
    logic [AW-1:0]          w_acc_sum;
    logic [AW-1:0]          w_acc_next;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (St) w_state_next = S_CALC;
            S_CALC:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        Idle = 1'b0;
        Done = 1'b0;
        case (r_state)
            S_IDLE:  Idle = 1'b1;
            S_DONE:  Done = 1'b1;
            default: begin
                Idle = 1'b0;
                Done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: one add-and-shift step
    // ------------------------------------------------------------------
    always_comb begin
        w_accept = (r_state == S_IDLE) && St;
        w_last   = (r_cnt == CNT_W'(WIDTH-1));
        w_u      = r_acc[AW-1:WIDTH];
        w_mext   = r_sgn ? {r_m[WIDTH-1], r_m} : {1'b0, r_m};

        // In signed mode the multiplier's MSB carries weight -2^(W-1),
        // so its partial product is subtracted rather than added.
        if (r_acc[0]) begin
            if (r_sgn && w_last) begin
                w_u_new = w_u - w_mext;
            end else begin
                w_u_new = w_u + w_mext;
            end
        end else begin
            w_u_new = w_u;
        end

        w_acc_sum  = {w_u_new, r_acc[WIDTH-1:0]};
        // Arithmetic shift keeps the partial product's sign in signed mode.
        w_acc_next = {(r_sgn ? w_u_new[WIDTH] : 1'b0), w_acc_sum[AW-1:1]};
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_m       <= '0;
            r_sgn     <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_produto <= '0;
        end else begin
            if (w_accept) begin
                r_m   <= Multiplicando;
                r_sgn <= Sgn;
                r_acc <= {{(WIDTH+1){1'b0}}, OperandoMultiplicador};
                r_cnt <= '0;
            end else if (r_state == S_CALC) begin
                r_acc <= w_acc_next;
                // For power-of-two WIDTH this wraps to 0 on the exit step.
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_produto <= w_acc_next[2*WIDTH-1:0];
                end
            end
        end
    end

    assign Produto = r_produto;

endmodule

// File: tb/tb_shift_add_mult_n.sv
module tb_shift_add_mult_n;

    logic        Clk;
    logic        Rst_n;

    logic        St4, Sgn4;
    logic [3:0]  M4, Q4;
    logic        Idle4, Done4;
    logic [7:0]  P4;

    logic        St8, Sgn8;
    logic [7:0]  M8, Q8;
    logic        Idle8, Done8;
    logic [15:0] P8;

    int n_checks = 0;
    int n_fail   = 0;

    shift_add_mult_n #(.WIDTH(4)) u_dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .St(St4), .Sgn(Sgn4),
        .Multiplicando(M4), .OperandoMultiplicador(Q4),
        .Idle(Idle4), .Done(Done4), .Produto(P4)
    );

    shift_add_mult_n #(.WIDTH(8)) u_dut8 (
        .Clk(Clk), .Rst_n(Rst_n), .St(St8), .Sgn(Sgn8),
        .Multiplicando(M8), .OperandoMultiplicador(Q8),
        .Idle(Idle8), .Done(Done8), .Produto(P8)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference product for the 4-bit instance.
    function automatic logic [7:0] ref4(input logic s, input logic [3:0] m, input logic [3:0] q);
        int a;
        int b;
        a = (s && m[3]) ? int'(m) - 16 : int'(m);
        b = (s && q[3]) ? int'(q) - 16 : int'(q);
        return 8'(a * b);
    endfunction

    // Runs one 4-bit operation starting at a negedge with the DUT idle.
    // Returns product at the Done cycle, edges from accept to Done, and
    // whether Idle was seen high during the operation or with Done.
    task automatic op4(input logic s, input logic [3:0] m, input logic [3:0] q,
                       output logic [7:0] p, output int lat, output bit bad);
        St4 = 1'b1; Sgn4 = s; M4 = m; Q4 = q;
        @(negedge Clk);
        St4 = 1'b0; Sgn4 = ~s; M4 = ~m; Q4 = ~q;
        lat = 0;
        bad = 1'b0;
        while (!Done4 && lat < 20) begin
            if (Idle4) bad = 1'b1;
            @(negedge Clk);
            lat++;
        end
        if (Idle4 && Done4) bad = 1'b1;
        p = P4;
        @(negedge Clk);
    endtask

    task automatic op8(input logic s, input logic [7:0] m, input logic [7:0] q,
                       output logic [15:0] p, output int lat);
        St8 = 1'b1; Sgn8 = s; M8 = m; Q8 = q;
        @(negedge Clk);
        St8 = 1'b0; M8 = ~m; Q8 = ~q;
        lat = 0;
        while (!Done8 && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
        p = P8;
        @(negedge Clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge Clk);
        n_checks++;
        if (Idle4 !== 1'b1 || Done4 !== 1'b0 || P4 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_w4: Idle=%b Done=%b P=%h, want Idle=1 Done=0 P=00", Idle4, Done4, P4);
        end
        n_checks++;
        if (Idle8 !== 1'b1 || Done8 !== 1'b0 || P8 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_w8: Idle=%b Done=%b P=%h, want Idle=1 Done=0 P=0000", Idle8, Done8, P8);
        end
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_unsigned_hold;
        logic [7:0] p;
        int lat;
        bit bad;
        op4(1'b0, 4'hF, 4'hF, p, lat, bad);
        n_checks++;
        if (p !== 8'hE1) begin
            n_fail++;
            $display("FAIL u15x15: got %h want e1", p);
        end
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL u15x15_latency: got %0d want 4", lat);
        end
        n_checks++;
        if (Idle4 !== 1'b1 || Done4 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_return: Idle=%b Done=%b want 1 0", Idle4, Done4);
        end
        // Second operation: Produto must hold 0xE1 until completion.
        St4 = 1'b1; Sgn4 = 1'b0; M4 = 4'd2; Q4 = 4'd3;
        @(negedge Clk);
        St4 = 1'b0; M4 = 4'd9; Q4 = 4'd9;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (P4 !== 8'hE1 || Done4 !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_step%0d: P=%h Done=%b want e1 0", i, P4, Done4);
            end
            @(negedge Clk);
        end
        n_checks++;
        if (Done4 !== 1'b1 || P4 !== 8'h06) begin
            n_fail++;
            $display("FAIL u2x3: Done=%b P=%h want 1 06", Done4, P4);
        end
        @(negedge Clk);
    endtask

    task automatic test_signed4;
        logic [3:0] tm [4];
        logic [3:0] tq [4];
        logic [7:0] te [4];
        logic [7:0] p;
        int lat;
        bit bad;
        tm[0] = 4'h8; tq[0] = 4'h8; te[0] = 8'h40;
        tm[1] = 4'h8; tq[1] = 4'h7; te[1] = 8'hC8;
        tm[2] = 4'h7; tq[2] = 4'hF; te[2] = 8'hF9;
        tm[3] = 4'h0; tq[3] = 4'hB; te[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            op4(1'b1, tm[i], tq[i], p, lat, bad);
            n_checks++;
            if (p !== te[i] || lat != 4) begin
                n_fail++;
                $display("FAIL signed4_%0d: got %h lat %0d want %h lat 4", i, p, lat, te[i]);
            end
        end
    endtask

    task automatic test_width8;
        logic       ts [3];
        logic [7:0] tm [3];
        logic [7:0] tq [3];
        logic [15:0] te [3];
        logic [15:0] p;
        int lat;
        ts[0] = 1'b0; tm[0] = 8'hFF; tq[0] = 8'hFF; te[0] = 16'hFE01;
        ts[1] = 1'b1; tm[1] = 8'h80; tq[1] = 8'h80; te[1] = 16'h4000;
        ts[2] = 1'b1; tm[2] = 8'h80; tq[2] = 8'h7F; te[2] = 16'hC080;
        for (int i = 0; i < 3; i++) begin
            op8(ts[i], tm[i], tq[i], p, lat);
            n_checks++;
            if (p !== te[i] || lat != 8) begin
                n_fail++;
                $display("FAIL w8_%0d: got %h lat %0d want %h lat 8", i, p, lat, te[i]);
            end
        end
    endtask

    // St held high for 20 edges with operands changing every cycle.
    // Accepts occur at edges 0,6,12,18; Done is seen after edges 4,10,16,22.
    task automatic test_back_to_back;
        logic [3:0] hm [24];
        logic [3:0] hq [24];
        logic       hs [24];
        int  dones;
        bit  exp_done;
        dones = 0;
        for (int k = 0; k < 24; k++) begin
            hm[k] = 4'((k + 3) % 16);
            hq[k] = 4'((k * k + 5) % 16);
            hs[k] = ((k % 4) == 2);
            St4 = (k < 20); Sgn4 = hs[k]; M4 = hm[k]; Q4 = hq[k];
            @(negedge Clk);
            exp_done = ((k % 6) == 4);
            n_checks++;
            if (Done4 !== exp_done || (Idle4 && Done4)) begin
                n_fail++;
                $display("FAIL b2b_done_edge%0d: Done=%b Idle=%b want Done=%b", k, Done4, Idle4, exp_done);
            end
            if (Done4 === 1'b1) begin
                dones++;
                if (k >= 4) begin
                    n_checks++;
                    if (P4 !== ref4(hs[k-4], hm[k-4], hq[k-4])) begin
                        n_fail++;
                        $display("FAIL b2b_prod_edge%0d: got %h want %h", k, P4, ref4(hs[k-4], hm[k-4], hq[k-4]));
                    end
                end
            end
        end
        St4 = 1'b0;
        n_checks++;
        if (dones != 4) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d want 4", dones);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset_abort;
        logic [7:0] p;
        int lat;
        bit bad;
        St4 = 1'b1; Sgn4 = 1'b0; M4 = 4'd11; Q4 = 4'd13;
        @(negedge Clk);
        St4 = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (Idle4 !== 1'b1 || Done4 !== 1'b0 || P4 !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_state: Idle=%b Done=%b P=%h want 1 0 00", Idle4, Done4, P4);
        end
        Rst_n = 1'b1;
        op4(1'b0, 4'd11, 4'd13, p, lat, bad);
        n_checks++;
        if (p !== 8'h8F || lat != 4) begin
            n_fail++;
            $display("FAIL abort_restart: got %h lat %0d want 8f lat 4", p, lat);
        end
    endtask

    task automatic test_reset_with_start;
        Rst_n = 1'b0; St4 = 1'b1; Sgn4 = 1'b0; M4 = 4'd3; Q4 = 4'd3;
        @(negedge Clk);
        n_checks++;
        if (Idle4 !== 1'b1 || P4 !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_st_reset: Idle=%b P=%h want 1 00", Idle4, P4);
        end
        Rst_n = 1'b1; St4 = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (Idle4 !== 1'b1 || Done4 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_st_dropped: Idle=%b Done=%b want 1 0", Idle4, Done4);
        end
    endtask

    task automatic test_exhaustive4;
        logic [7:0] p;
        int lat;
        bit bad;
        for (int s = 0; s < 2; s++) begin
            for (int m = 0; m < 16; m++) begin
                for (int q = 0; q < 16; q++) begin
                    op4(s[0], 4'(m), 4'(q), p, lat, bad);
                    n_checks++;
                    if (p !== ref4(s[0], 4'(m), 4'(q)) || lat != 4 || bad) begin
                        n_fail++;
                        $display("FAIL exh s%0d m%0d q%0d: got %h lat %0d idle_err %0d want %h lat 4",
                                 s, m, q, p, lat, bad, ref4(s[0], 4'(m), 4'(q)));
                    end
                end
            end
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        St4 = 1'b0; Sgn4 = 1'b0; M4 = '0; Q4 = '0;
        St8 = 1'b0; Sgn8 = 1'b0; M8 = '0; Q8 = '0;
        test_reset();
        test_unsigned_hold();
        test_signed4();
        test_width8();
        test_back_to_back();
        test_reset_abort();
        test_reset_with_start();
        test_exhaustive4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/shift_add_mult_n.md
# shift_add_mult_n

Parametrised sequential shift-add multiplier, successor to the fixed 4-bit multiplier datapath/controller pair. It multiplies two WIDTH-bit operands in unsigned or two's-complement mode, selected per operation. It performs one add-and-shift step per clock and holds the 2·WIDTH-bit result in a dedicated output register until the next completion. It sits behind the same St/Idle/Done handshake as its predecessor, so existing controllers drive it unchanged.

## Interface
- WIDTH, default 4: operand width in bits. Legal range is ≥2; it is verified at 4 and 8.
- Clk  input  1  sole clock; all state updates on rising edge.
- Rst_n  input  1  synchronous, active-low reset; sampled on rising Clk.
- St  input  1  start request; accepted only while Idle=1.
- Sgn  input  1  mode, sampled with St: 0 = unsigned, 1 = two's-complement signed.
- Multiplicando  input  WIDTH  multiplicand M; sampled with St.
- OperandoMultiplicador  input  WIDTH  multiplier Q; sampled with St.
- Idle  output  1  high in IDLE state.
- Done  output  1  one-cycle pulse when Produto has just been updated.
- Produto  output  2·WIDTH  result register; changes only at completion or reset.

## Operation
- State machine: IDLE, CALC, DONE (2-bit encoded).
- Rst_n=0 at an edge forces IDLE from any state. It clears Produto, the accumulator, the step counter, and the latched M and mode. Idle=1, Done=0 from the next cycle.
- IDLE, St=1: latch M, Sgn, and Q.
  - Load accumulator ACC (2·WIDTH+1 bits) = {(WIDTH+1)'b0, Q}.
  - Clear counter, go to CALC.
- IDLE, St=0: remain.
- CALC, one step per edge, WIDTH steps total:
  - Upper part U = ACC[2W:W] (W+1 bits). Mext = M zero-extended (Sgn=0) or sign-extended (Sgn=1) to W+1 bits.
  - If ACC[0]=1: U' = U + Mext. In signed mode on the last step (counter = WIDTH-1), U' = U − Mext instead. Otherwise U' = U.
  - ACC ← {U', ACC[W-1:0]} shifted right by 1. The shift is logical (MSB←0) when Sgn=0 and arithmetic (MSB←U'[W]) when Sgn=1.
  - Counter increments. On the step where counter = WIDTH-1, Produto ← ACC_next[2W-1:0], go to DONE.
- DONE: Done=1, Idle=0. The next edge goes to IDLE unconditionally.
- St is ignored in CALC and DONE; no queuing.
- Input changes on Multiplicando, OperandoMultiplicador, and Sgn outside the St-accept edge have no effect.
- Arithmetic rules:
  - The W+1-bit upper sum never overflows: unsigned max (2^W−1)·2 fits, and signed −M for M = −2^(W−1) fits.
  - The result is exact: unsigned range 0..(2^W−1)^2; signed range −2^(W−1)(2^(W−1)−1)..2^(2W−2).
- Counter width is clog2(WIDTH). For WIDTH a power of two the counter wraps to 0 exactly at the exit step, and this wrap is harmless.

## Timing
- Reset values: Idle=1, Done=0, Produto=0.
- Let E0 be the edge where St=1 is sampled in IDLE.
  - Steps occur on edges E1..EW. Produto is updated at EW.
  - Done=1 in the cycle after EW; Idle returns to 1 after EW+1.
- Latency: Done rises W edges after acceptance. Minimum initiation interval is W+2 edges, because St held high continuously restarts at EW+1.
- Idle=0 from E0 through EW+1. Idle and Done are never high together.
- Rst_n=0 mid-CALC aborts the operation. No Done is produced, Produto reads 0, and an St on the edge after reset release is accepted.
- Rst_n=0 simultaneous with St=1 resolves to reset; the start is dropped.
- Produto holds its previous result throughout CALC. Intermediate ACC values are never visible.

## Test plan
- WIDTH=4, Sgn=0, M=15, Q=15, St pulse → Done 4 edges later; Produto=0x00E1, held unchanged until next completion.
- WIDTH=4, Sgn=1: the following pairs must all be correct:
  - (−8)(−8) → 0x40
  - (−8)(7) → 0xC8
  - (7)(−1) → 0xF9
  - (0)(−5) → 0x00
- WIDTH=4: St held high for 20 cycles with changing operands.
  - Only operands present at each IDLE-accept edge are used.
  - Exactly one Done per 6 edges.
  - Operand changes during CALC do not affect the result.
- WIDTH=4: Rst_n=0 for one edge at step 2 of 11×13.
  - Idle=1 and Done=0 next cycle; Produto=0.
  - A fresh 11×13 then yields 0x8F.
- WIDTH=8: the following must all be correct:
  - Sgn=0, 255×255 → 0xFE01
  - Sgn=1, (−128)(−128) → 0x4000
  - Sgn=1, (−128)(127) → 0xC080
- WIDTH=4 exhaustive: all 256 operand pairs in both modes are compared against a reference model. Also check that Idle/Done are mutually exclusive and that latency is exactly 4.
